xor_response_checker: RTL and testbench



---
 rtl/xor_chk_pkg.sv | 6 +
 rtl/xor_response_checker_if.sv | 25 ++
 rtl/xor_chk_delay.sv | 31 +++
 rtl/xor_response_checker.sv | 74 +++++++
 tb/tb_xor_response_checker.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/xor_chk_pkg.sv
// xor_chk_pkg: shared state encoding and widths for the XOR response checker.
package xor_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DW = 4;
  localparam int MAX_LATENCY = 4;
endpackage

// File: rtl/xor_response_checker_if.sv
// xor_response_checker_if: stimulus/response and verdict signals between harness and checker.
interface xor_response_checker_if #(parameter int CNT_W = 8);
  logic start;
  logic stim_vld;
  logic [xor_chk_pkg::DW-1:0] a;
  logic [xor_chk_pkg::DW-1:0] b;
  logic [xor_chk_pkg::DW-1:0] y;
  logic busy;
  logic done;
  logic pass;
  logic mismatch;
  logic [CNT_W-1:0] chk_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] fail_idx;
  logic [xor_chk_pkg::DW-1:0] fail_exp;
  logic [xor_chk_pkg::DW-1:0] fail_y;
  modport master (
    output start, stim_vld, a, b, y,
    input  busy, done, pass, mismatch, chk_count, err_count, fail_idx, fail_exp, fail_y
  );
  modport slave (
    input  start, stim_vld, a, b, y,
    output busy, done, pass, mismatch, chk_count, err_count, fail_idx, fail_exp, fail_y
  );
endinterface

// File: rtl/xor_chk_delay.sv
// xor_chk_delay: LATENCY-stage valid+data shift register, async reset and sync clear.
module xor_chk_delay #(
  parameter int LATENCY = 1,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  output logic          pop_vld,
  output logic [DW-1:0] pop_dat
);
  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0][DW-1:0] dat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clr) begin
      vld <= '0;
      dat <= '0;
    end else begin
      vld[0] <= push_vld;
      dat[0] <= push_dat;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end
  assign pop_vld = vld[LATENCY-1];
  assign pop_dat = dat[LATENCY-1];
endmodule

// File: rtl/xor_response_checker.sv
// xor_response_checker: checks a 4-bit XOR DUT against a^b delayed by LATENCY; XOR_CHK_FIRST_FAIL_EN adds first-failure capture.
module xor_response_checker
  import xor_chk_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  xor_response_checker_if.slave bus
);
  localparam logic [CNT_W-1:0] NUM = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VECTORS - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] acc_count;
  logic clr, accept, cmp, bad, pop_vld;
  logic [DW-1:0] exp_dat;
  xor_chk_delay #(.LATENCY(LATENCY), .DW(DW)) u_delay (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .push_vld(accept),
    .push_dat(bus.a ^ bus.b),
    .pop_vld(pop_vld),
    .pop_dat(exp_dat)
  );
  // Entering RUN from IDLE or DONE restarts the run; start during RUN is ignored.
  always_comb begin
    clr = bus.start && (state != RUN);
    accept = (state == RUN) && bus.stim_vld && (acc_count < NUM);
    cmp = (state == RUN) && pop_vld;
    bad = cmp && (bus.y != exp_dat);
    state_nxt = clr ? RUN : ((cmp && bus.chk_count == LAST) ? DONE : state);
    bus.busy = state == RUN;
    bus.done = state == DONE;
    bus.pass = (state == DONE) && (bus.err_count == '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clr) begin
      acc_count <= '0;
      bus.chk_count <= '0;
      bus.err_count <= '0;
      bus.mismatch <= 1'b0;
    end else begin
      acc_count <= acc_count + CNT_W'(accept);
      bus.chk_count <= bus.chk_count + CNT_W'(cmp);
      bus.err_count <= bus.err_count + CNT_W'(bad);
      bus.mismatch <= bad;
    end
  end
`ifdef XOR_CHK_FIRST_FAIL_EN
  // err_count still zero marks the first mismatch of the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clr) begin
      bus.fail_idx <= '0;
      bus.fail_exp <= '0;
      bus.fail_y <= '0;
    end else if (bad && bus.err_count == '0) begin
      bus.fail_idx <= bus.chk_count;
      bus.fail_exp <= exp_dat;
      bus.fail_y <= bus.y;
    end
  end
`else
  assign bus.fail_idx = '0;
  assign bus.fail_exp = '0;
  assign bus.fail_y = '0;
`endif
endmodule

// File: tb/tb_xor_response_checker.sv
// tb_xor_response_checker: directed checks of the XOR response checker at LATENCY 1 and 2.
module tb_xor_response_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stim_vld = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [3:0] inj = '0;
  logic two_cycle = 1'b1;
  logic [3:0] d1, d2;
  int errors = 0;
  int checks = 0;
  int mm1 = 0;
  int mm_snap;
  always #5 clk = ~clk;
  xor_response_checker_if #(.CNT_W(8)) bus1 ();
  xor_response_checker_if #(.CNT_W(8)) bus2 ();
  assign bus1.start = start;
  assign bus1.stim_vld = stim_vld;
  assign bus1.a = a;
  assign bus1.b = b;
  assign bus1.y = d1;
  assign bus2.start = start;
  assign bus2.stim_vld = stim_vld;
  assign bus2.a = a;
  assign bus2.b = b;
  assign bus2.y = two_cycle ? d2 : d1;
  xor_response_checker #(.LATENCY(1), .NUM_VECTORS(16), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  xor_response_checker #(.LATENCY(2), .NUM_VECTORS(16), .CNT_W(8)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  always @(posedge clk) begin
    d1 <= a ^ b ^ inj;
    d2 <= d1;
  end
  always @(negedge clk) if (bus1.mismatch === 1'b1) mm1 <= mm1 + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic run_vectors(input int n, input int err_at);
    for (int i = 0; i < n; i++) begin
      a = 4'(i);
      b = 4'd1;
      stim_vld = 1'b1;
      inj = (i == err_at) ? 4'd2 : 4'd0;
      @(negedge clk);
    end
    stim_vld = 1'b0;
    inj = '0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (bus2.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", 32'(bus2.done), 1);
  endtask
  initial begin
    #1;
    check("rst_busy", 32'(bus1.busy), 0);
    check("rst_done", 32'(bus1.done), 0);
    check("rst_pass", 32'(bus1.pass), 0);
    check("rst_chk", 32'(bus1.chk_count), 0);
    check("rst_err", 32'(bus1.err_count), 0);
    check("rst_mm", 32'(bus1.mismatch), 0);
    check("rst_fidx", 32'(bus1.fail_idx), 0);
    @(negedge clk) reset = 1'b0;
    // clean run, both latencies
    pulse_start();
    check("run_busy", 32'(bus1.busy), 1);
    run_vectors(16, -1);
    check("chk15", 32'(bus1.chk_count), 15);
    check("not_done_yet", 32'(bus1.done), 0);
    @(negedge clk);
    check("chk16", 32'(bus1.chk_count), 16);
    check("done_l1", 32'(bus1.done), 1);
    check("pass_l1", 32'(bus1.pass), 1);
    check("done_l2_late", 32'(bus2.done), 0);
    wait_done();
    check("pass_l2", 32'(bus2.pass), 1);
    check("chk_l2", 32'(bus2.chk_count), 16);
    check("err_l1", 32'(bus1.err_count), 0);
    check("busy_done", 32'(bus1.busy), 0);
    check("mm_none", 32'(mm1), 0);
    // one bad vector: a=5 observed as 6 instead of 4
    mm_snap = mm1;
    pulse_start();
    check("restart_chk", 32'(bus1.chk_count), 0);
    check("restart_done", 32'(bus1.done), 0);
    run_vectors(16, 5);
    wait_done();
    check("err1", 32'(bus1.err_count), 1);
    check("err1_l2", 32'(bus2.err_count), 1);
    check("mm_one", 32'(mm1 - mm_snap), 1);
    check("pass0", 32'(bus1.pass), 0);
    check("chk16_err", 32'(bus1.chk_count), 16);
`ifdef XOR_CHK_FIRST_FAIL_EN
    check("fail_idx", 32'(bus1.fail_idx), 5);
    check("fail_exp", 32'(bus1.fail_exp), 4);
    check("fail_y", 32'(bus1.fail_y), 6);
`else
    check("fail_idx0", 32'(bus1.fail_idx), 0);
    check("fail_exp0", 32'(bus1.fail_exp), 0);
    check("fail_y0", 32'(bus1.fail_y), 0);
`endif
    // start from DONE clears the previous verdict on that edge
    pulse_start();
    check("clr_err", 32'(bus1.err_count), 0);
    check("clr_fidx", 32'(bus1.fail_idx), 0);
    check("clr_fy", 32'(bus1.fail_y), 0);
    check("clr_pass", 32'(bus1.pass), 0);
    run_vectors(16, -1);
    wait_done();
    check("clean_pass", 32'(bus1.pass), 1);
    // asynchronous reset mid-run
    pulse_start();
    run_vectors(8, 3);
    check("mid_chk", 32'(bus1.chk_count), 7);
    #2 reset = 1'b1;
    #1;
    check("arst_chk", 32'(bus1.chk_count), 0);
    check("arst_err", 32'(bus1.err_count), 0);
    check("arst_busy", 32'(bus1.busy), 0);
    check("arst_done", 32'(bus1.done), 0);
    check("arst_mm", 32'(bus1.mismatch), 0);
    @(negedge clk) reset = 1'b0;
    // stim_vld in IDLE is ignored
    run_vectors(4, -1);
    @(negedge clk);
    check("idle_chk", 32'(bus1.chk_count), 0);
    check("idle_busy", 32'(bus1.busy), 0);
    // 20 vectors offered, only 16 accepted
    pulse_start();
    run_vectors(20, -1);
    wait_done();
    check("cap_chk", 32'(bus1.chk_count), 16);
    check("cap_chk_l2", 32'(bus2.chk_count), 16);
    check("cap_pass", 32'(bus1.pass), 1);
    // LATENCY=2 checker against a 1-cycle DUT model must fail
    two_cycle = 1'b0;
    pulse_start();
    run_vectors(16, -1);
    wait_done();
    check("l2_short_fail", 32'(bus2.err_count != 0), 1);
    check("l2_short_pass", 32'(bus2.pass), 0);
    check("l1_still_pass", 32'(bus1.pass), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
